sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_pkg.sv | 18 +
 rtl/sqrt_rr_sel.sv | 24 ++
 rtl/sqrt_arbiter.sv | 106 ++++++++++
 tb/tb_sqrt_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the two-requester square-root arbiter.
`timescale 1ns/1ps
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/sqrt_rr_sel.sv
// Round-robin pick between requesters A and B; a tie goes to whoever was not served last.
`timescale 1ns/1ps
module sqrt_rr_sel
    import sqrt_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       grant_vld
);

    always_comb begin
        grant = REQ_A;
        case (req)
            2'b01:   grant = REQ_A;
            2'b10:   grant = REQ_B;
            2'b11:   grant = (last == REQ_A) ? REQ_B : REQ_A;
            default: grant = REQ_A;
        endcase
    end

    assign grant_vld = |req;

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one external square-root core between two requesters; all outputs registered.
`timescale 1ns/1ps
module sqrt_arbiter
    import sqrt_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [WIDTH-1:0]   d_a,
    input  logic [WIDTH-1:0]   d_b,
    output logic [1:0]         ack,
    output logic [1:0]         res_valid,
    output logic [WIDTH/2-1:0] res_q,
    output logic               res_err,
    output logic               busy,
    output logic               sq_start,
    output logic [WIDTH-1:0]   sq_d,
    input  logic               sq_done,
    input  logic [WIDTH/2-1:0] sq_q
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_reg;
    logic             sel_grant;
    logic             sel_vld;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    sqrt_rr_sel u_rr_sel (
        .req       (req),
        .last      (last),
        .grant     (sel_grant),
        .grant_vld (sel_vld)
    );

    assign sq_d = op_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= REQ_A;
            last      <= REQ_B;
            cnt       <= '0;
            op_reg    <= '0;
            ack       <= '0;
            res_valid <= '0;
            res_q     <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
            sq_start  <= 1'b0;
        end else begin
            ack       <= '0;
            res_valid <= '0;
            sq_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        owner    <= sel_grant;
                        op_reg   <= sel_grant ? d_b : d_a;
                        ack      <= onehot(sel_grant);
                        sq_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // cnt==0 is the first WAIT cycle: a done level left over from before start is ignored
                    if (cnt != '0 && sq_done) begin
                        res_q     <= sq_q;
                        res_err   <= 1'b0;
                        res_valid <= onehot(owner);
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        res_q     <= '0;
                        res_err   <= 1'b1;
                        res_valid <= onehot(owner);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    last  <= owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural square-root core stub and a result scoreboard.
`timescale 1ns/1ps
module tb_sqrt_arbiter;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int QW      = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [WIDTH-1:0] d_a = '0;
    logic [WIDTH-1:0] d_b = '0;
    logic [1:0]       ack;
    logic [1:0]       res_valid;
    logic [QW-1:0]    res_q;
    logic             res_err;
    logic             busy;
    logic             sq_start;
    logic [WIDTH-1:0] sq_d;
    logic             sq_done;
    logic [QW-1:0]    sq_q;

    int n_cmp = 0;
    int n_err = 0;
    // stub core: 0 = done pulse in WAIT3, 1 = done stuck high, 2 = never done, 3 = done in WAIT64
    int mode = 0;
    int scnt;

    typedef struct packed {
        logic [1:0]    rv;
        logic [QW-1:0] q;
        logic          err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sqrt_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d_a       (d_a),
        .d_b       (d_b),
        .ack       (ack),
        .res_valid (res_valid),
        .res_q     (res_q),
        .res_err   (res_err),
        .busy      (busy),
        .sq_start  (sq_start),
        .sq_d      (sq_d),
        .sq_done   (sq_done),
        .sq_q      (sq_q)
    );

    function automatic logic [QW-1:0] isqrt(input logic [WIDTH-1:0] d);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(d)) r++;
        return QW'(r);
    endfunction

    always_comb sq_q = isqrt(sq_d);

    always_ff @(posedge clk) begin
        if (rst)           scnt <= 0;
        else if (sq_start) scnt <= 1;
        else               scnt <= scnt + 1;
    end

    always_comb sq_done = (mode == 1) || (mode == 0 && scnt == 3) || (mode == 3 && scnt == 64);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_res(input logic [1:0] rv, input logic [QW-1:0] q, input logic err);
        exp_t e;
        e.rv  = rv;
        e.q   = q;
        e.err = err;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            check("ack_rv_excl",
                  32'({$onehot0(ack), $onehot0(res_valid), !((|ack) && (|res_valid))}), 32'h7);
            if (res_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_res", 32'(res_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("res_valid", 32'(res_valid), 32'(e.rv));
                    check("res_q", 32'(res_q), 32'(e.q));
                    check("res_err", 32'(res_err), 32'(e.err));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'h0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'h0);
        check({tag, "_res_q"}, 32'(res_q), 32'h0);
        check({tag, "_res_err"}, 32'(res_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_sq_start"}, 32'(sq_start), 32'h0);
        check({tag, "_sq_d"}, 32'(sq_d), 32'h0);
    endtask

    // Waits for every expected result to be popped, drops req, and lands on an IDLE cycle.
    task automatic finish_txn(input int bound);
        int i = 0;
        while (sb.size() != 0 && i < bound) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("sb_drain", 32'(sb.size()), 32'h0);
        req = 2'b00;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
    endtask

    task automatic measure_latency(input string tag, input int want);
        int n = 0;
        while (res_valid == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'(want));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        // A only, 144 -> 12
        d_a = 16'd144;
        expect_res(2'b01, 8'd12, 1'b0);
        req = 2'b01;
        @(negedge clk);
        check("a_ack", 32'(ack), 32'h1);
        check("a_sq_start", 32'(sq_start), 32'h1);
        check("a_sq_d", 32'(sq_d), 32'd144);
        check("a_busy", 32'(busy), 32'h1);
        req = 2'b00;
        finish_txn(50);

        // B only, 65535 -> 255, then 0 -> 0
        d_b = 16'hFFFF;
        expect_res(2'b10, 8'd255, 1'b0);
        req = 2'b10;
        @(negedge clk);
        check("b_ack", 32'(ack), 32'h2);
        req = 2'b00;
        finish_txn(50);
        d_b = 16'd0;
        expect_res(2'b10, 8'd0, 1'b0);
        req = 2'b10;
        @(negedge clk);
        check("b0_ack", 32'(ack), 32'h2);
        check("b0_sq_d", 32'(sq_d), 32'h0);
        req = 2'b00;
        finish_txn(50);

        // Tie from reset: A first, then alternate while both are held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d_a = 16'd100;
        d_b = 16'd81;
        expect_res(2'b01, 8'd10, 1'b0);
        expect_res(2'b10, 8'd9, 1'b0);
        expect_res(2'b01, 8'd10, 1'b0);
        expect_res(2'b10, 8'd9, 1'b0);
        req = 2'b11;
        @(negedge clk);
        check("tie_ack", 32'(ack), 32'h1);
        finish_txn(400);

        // Done stuck high before start: taken in the second WAIT cycle
        mode = 1;
        d_a = 16'd144;
        expect_res(2'b01, 8'd12, 1'b0);
        req = 2'b01;
        @(negedge clk);
        check("hd_ack", 32'(ack), 32'h1);
        req = 2'b00;
        @(negedge clk);
        check("hd_wait1", 32'(res_valid), 32'h0);
        @(negedge clk);
        check("hd_wait2", 32'(res_valid), 32'h0);
        @(negedge clk);
        check("hd_resp", 32'(res_valid), 32'h1);
        finish_txn(5);

        // Timeout: 64 WAIT cycles then an error response
        mode = 2;
        expect_res(2'b01, 8'd0, 1'b1);
        req = 2'b01;
        @(negedge clk);
        check("to_ack", 32'(ack), 32'h1);
        req = 2'b00;
        measure_latency("to_latency", 65);
        finish_txn(5);

        // Done arrives in the very cycle the timeout fires: done wins
        mode = 3;
        expect_res(2'b01, 8'd12, 1'b0);
        req = 2'b01;
        @(negedge clk);
        check("tie_to_ack", 32'(ack), 32'h1);
        req = 2'b00;
        measure_latency("tie_to_latency", 65);
        finish_txn(5);

        // Reset mid-WAIT abandons the operation
        mode = 2;
        req = 2'b01;
        @(negedge clk);
        check("rw_ack", 32'(ack), 32'h1);
        req = 2'b00;
        repeat (5) @(negedge clk);
        check("rw_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rw");
        repeat (80) @(negedge clk);
        mode = 0;
        d_a = 16'd49;
        expect_res(2'b01, 8'd7, 1'b0);
        req = 2'b01;
        @(negedge clk);
        check("rw49_ack", 32'(ack), 32'h1);
        req = 2'b00;
        finish_txn(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
